// File: rtl/div_freq_multi_if.sv
// Control and strobe bundle of the multi-channel clock divider.
// The master drives the run/load/sync controls; the slave (the divider) drives the outputs.
interface div_freq_multi_if #(
  parameter int NCH = 2,
  parameter int W   = 16
);
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   load;
  logic [NCH*W-1:0] div_in;
  logic             sync;
  logic [NCH-1:0]   clkout;
  logic [NCH-1:0]   rise;
  logic [NCH-1:0]   fall;
  logic [NCH-1:0]   pend;

  modport master (
    output en, load, div_in, sync,
    input  clkout, rise, fall, pend
  );

  modport slave (
    input  en, load, div_in, sync,
    output clkout, rise, fall, pend
  );
endinterface

// File: rtl/div_freq_multi.sv
// Multi-channel programmable clock divider / strobe generator.
// Each channel is a down-counter that toggles its clock at terminal count and
// reloads from a shadow divisor there, so a new divisor never cuts a half period short.
module div_freq_multi #(
  parameter int NCH     = 2,
  parameter int W       = 16,
  parameter int DEF_DIV = 5
) (
  input  logic            clk,
  input  logic            reset,
  div_freq_multi_if.slave bus
);

  localparam logic [W-1:0] DEF = W'(DEF_DIV);

  logic [W-1:0]   cnt_reg    [NCH];
  logic [W-1:0]   shadow_reg [NCH];
  logic [W-1:0]   active_reg [NCH];
  logic [NCH-1:0] clkout_reg;
  logic [NCH-1:0] rise_reg;
  logic [NCH-1:0] fall_reg;
  logic [NCH-1:0] pend_reg;

  logic [W-1:0]   din         [NCH];
  logic [W-1:0]   shadow_next [NCH];
  logic [W-1:0]   active_next [NCH];
  logic [W-1:0]   cnt_next    [NCH];
  logic [NCH-1:0] clkout_next;
  logic [NCH-1:0] rise_next;
  logic [NCH-1:0] fall_next;
  logic [NCH-1:0] pend_next;
  logic [NCH-1:0] hold;
  logic [NCH-1:0] tc;

  // Per-channel next-state: a held channel (disabled or being synced) parks at
  // phase 0 with the freshest divisor; a running channel reloads only at TC.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign din[gi]         = bus.div_in[gi*W +: W];
      assign shadow_next[gi] = bus.load[gi] ? din[gi] : shadow_reg[gi];
      assign hold[gi]        = !bus.en[gi] || bus.sync;
      assign tc[gi]          = (cnt_reg[gi] == '0);
      assign active_next[gi] = (hold[gi] || tc[gi]) ? shadow_next[gi] : active_reg[gi];
      assign cnt_next[gi]    = (hold[gi] || tc[gi]) ? shadow_next[gi] : cnt_reg[gi] - 1'b1;
      assign clkout_next[gi] = hold[gi] ? 1'b0 : (clkout_reg[gi] ^ tc[gi]);
      assign rise_next[gi]   = !hold[gi] && tc[gi] && !clkout_reg[gi];
      assign fall_next[gi]   = !hold[gi] && tc[gi] &&  clkout_reg[gi];
      assign pend_next[gi]   = (shadow_next[gi] != active_next[gi]);
    end
  endgenerate

  // State registers for all channels; reset wins over load, sync and TC.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_reg[i]    <= DEF;
        shadow_reg[i] <= DEF;
        active_reg[i] <= DEF;
      end
      clkout_reg <= '0;
      rise_reg   <= '0;
      fall_reg   <= '0;
      pend_reg   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_reg[i]    <= cnt_next[i];
        shadow_reg[i] <= shadow_next[i];
        active_reg[i] <= active_next[i];
      end
      clkout_reg <= clkout_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      pend_reg   <= pend_next;
    end
  end

  assign bus.clkout = clkout_reg;
  assign bus.rise   = rise_reg;
  assign bus.fall   = fall_reg;
  assign bus.pend   = pend_reg;

endmodule

// File: tb/tb_div_freq_multi.sv
// Self-checking bench for div_freq_multi: directed scenarios followed by random
// stimulus, every cycle compared against a half-period reference model.
module tb_div_freq_multi;

  localparam int NCH = 2;
  localparam int W   = 16;
  localparam int DEF = 5;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  div_freq_multi_if #(.NCH(NCH), .W(W)) bus ();

  div_freq_multi #(.NCH(NCH), .W(W), .DEF_DIV(DEF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: each channel remembers how many enabled edges have elapsed
  // in the current half period and toggles when that reaches divisor+1.
  int m_sh  [NCH];
  int m_act [NCH];
  int m_el  [NCH];
  bit m_clk [NCH];
  bit m_rise[NCH];
  bit m_fall[NCH];
  bit m_pend[NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      int sh_n;
      sh_n = bus.load[c] ? int'(bus.div_in[c*W +: W]) : m_sh[c];
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (reset) begin
        m_sh[c] = DEF; m_act[c] = DEF; m_el[c] = 0; m_clk[c] = 1'b0;
        m_pend[c] = 1'b0;
        continue;
      end
      if (!bus.en[c] || bus.sync) begin
        m_clk[c] = 1'b0;
        m_act[c] = sh_n;
        m_el[c]  = 0;
      end else begin
        m_el[c]++;
        if (m_el[c] == m_act[c] + 1) begin
          if (m_clk[c]) m_fall[c] = 1'b1; else m_rise[c] = 1'b1;
          m_clk[c] = !m_clk[c];
          m_act[c] = sh_n;
          m_el[c]  = 0;
        end
      end
      m_sh[c]   = sh_n;
      m_pend[c] = (m_sh[c] != m_act[c]);
    end
  endtask

  // One clock: model consumes the inputs present at the edge, then outputs are compared.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("clkout%0d", c), 32'(bus.clkout[c]), 32'(m_clk[c]));
      check($sformatf("rise%0d", c),   32'(bus.rise[c]),   32'(m_rise[c]));
      check($sformatf("fall%0d", c),   32'(bus.fall[c]),   32'(m_fall[c]));
      check($sformatf("pend%0d", c),   32'(bus.pend[c]),   32'(m_pend[c]));
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load_pulse(input logic [NCH-1:0] mask, input int d0, input int d1);
    bus.load   = mask;
    bus.div_in = {W'(d1), W'(d0)};
    step();
    bus.load   = '0;
    $display("load mask=%b ch0=%0d ch1=%0d", mask, d0, d1);
  endtask

  task automatic sync_pulse();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    $display("sync pulse");
  endtask

  initial begin
    reset = 1'b1;
    bus.en = '0; bus.load = '0; bus.div_in = '0; bus.sync = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_sh[c] = 0; m_act[c] = 0; m_el[c] = 0;
      m_clk[c] = 0; m_rise[c] = 0; m_fall[c] = 0; m_pend[c] = 0;
    end

    // Reset values, then ch0 alone at the default divisor.
    run(2);
    reset = 1'b0;
    $display("reset released, enable ch0 at default divisor");
    bus.en = 2'b01;
    run(30);

    // Reprogram ch0 mid half period; pend visible until the applying TC.
    run(2);
    load_pulse(2'b01, 2, 0);
    run(25);

    // ch1 at divisor 0 gives clk/2.
    load_pulse(2'b10, 2, 0);
    bus.en = 2'b11;
    $display("enable ch1 at divisor 0");
    run(12);

    // ch0=3, ch1=7, then realign phases with sync.
    load_pulse(2'b11, 3, 7);
    run(20);
    sync_pulse();
    run(40);

    // Drop ch0 while its clock is high, then re-enable.
    begin
      int guard = 0;
      while (!m_clk[0] && guard < 50) begin step(); guard++; end
      check("wait_ch0_high", 32'(m_clk[0]), 32'd1);
    end
    bus.en = 2'b10;
    $display("disable ch0 while high");
    step();
    bus.en = 2'b11;
    $display("re-enable ch0");
    run(20);

    // Reset coinciding with load and sync.
    reset = 1'b1; bus.load = 2'b11; bus.div_in = {W'(9), W'(1)}; bus.sync = 1'b1;
    $display("reset with load and sync");
    step();
    reset = 1'b0; bus.load = '0; bus.sync = 1'b0;
    run(15);

    // Random stimulus against the model.
    for (int k = 0; k < 1500; k++) begin
      bus.en     = ($urandom_range(0, 19) == 0) ? NCH'($urandom) : bus.en;
      bus.load   = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
      bus.div_in = {W'($urandom_range(0, 9)), W'($urandom_range(0, 9))};
      bus.sync   = ($urandom_range(0, 49) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; bus.load = '0; bus.sync = 1'b0;
    $display("random phase done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
